// File: rtl/pipe_pkg.sv
// Shared sizing helpers for the elastic pipeline register chain.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package pipe_pkg;

    // Width of the occupancy counter: wide enough for 2*DEPTH entries plus headroom
    function automatic int pipe_cnt_w(input int depth);
        return $clog2(2 * depth + 2);
    endfunction

    // Number of words the chain can hold
    function automatic int pipe_cap(input int depth, input int skid);
        return depth * (1 + skid);
    endfunction

endpackage

// File: rtl/pipe_hs_stage.sv
// One valid/ready register stage, either a main reg plus skid reg or a plain reg.
// Latency: 1 cycle from accept to dn_valid.
// Backpressure: SKID=1 gives a registered up_ready (~skid_valid); SKID=0 passes ready through combinationally.
module pipe_hs_stage #(
    parameter int WIDTH = 32,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    input  logic             dn_ready
);

    logic             mv;
    logic [WIDTH-1:0] md;

    assign dn_valid = mv;
    assign dn_data  = md;

    if (SKID != 0) begin : g_skid
        logic             sv;
        logic [WIDTH-1:0] sd;

        // Ready depends only on the skid slot, so it never chains combinationally
        assign up_ready = ~sv;

        // Main reg refills from skid first (keeps order), skid catches a word only while main is stalled
        always_ff @(posedge clk) begin
            if (!rst) begin
                mv <= 1'b0;
                md <= '0;
                sv <= 1'b0;
                sd <= '0;
            end else if (clr) begin
                mv <= 1'b0;
                sv <= 1'b0;
            end else if (!mv || dn_ready) begin
                if (sv) begin
                    mv <= 1'b1;
                    md <= sd;
                    sv <= 1'b0;
                end else begin
                    mv <= up_valid;
                    if (up_valid) begin
                        md <= up_data;
                    end
                end
            end else if (up_valid && !sv) begin
                sv <= 1'b1;
                sd <= up_data;
            end
        end
    end else begin : g_plain
        // Accept whenever the register is empty or being drained this cycle
        assign up_ready = ~mv | dn_ready;

        // Plain register: load on every cycle the stage is ready
        always_ff @(posedge clk) begin
            if (!rst) begin
                mv <= 1'b0;
                md <= '0;
            end else if (clr) begin
                mv <= 1'b0;
            end else if (up_ready) begin
                mv <= up_valid;
                if (up_valid) begin
                    md <= up_data;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_reg_hs.sv
// Elastic pipeline register chain of DEPTH handshake stages with flush and occupancy count.
// Latency: DEPTH-1 edges after the accepting edge when empty; 1 word/cycle sustained.
// Backpressure: out_ready low fills the chain; in_ready drops when the head stage cannot take more.
module pipe_reg_hs
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int SKID  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [pipe_cnt_w(DEPTH)-1:0] count
);

    localparam int CW = pipe_cnt_w(DEPTH);
    localparam logic [CW-1:0] ONE = 1;

    // Each stage owns its own link signals so the ready chain stays a set of distinct nets
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_vld;
        logic [WIDTH-1:0] up_dat;
        logic             up_rdy;
        logic             dn_vld;
        logic [WIDTH-1:0] dn_dat;
        logic             dn_rdy;

        if (i == 0) begin : g_head
            assign up_vld = in_valid;
            assign up_dat = in_data;
        end else begin : g_mid
            assign up_vld = g_stage[i-1].dn_vld;
            assign up_dat = g_stage[i-1].dn_dat;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_rdy = out_ready;
        end else begin : g_link
            assign dn_rdy = g_stage[i+1].up_rdy;
        end

        pipe_hs_stage #(
            .WIDTH (WIDTH),
            .SKID  (SKID)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .up_valid (up_vld),
            .up_data  (up_dat),
            .up_ready (up_rdy),
            .dn_valid (dn_vld),
            .dn_data  (dn_dat),
            .dn_ready (dn_rdy)
        );
    end

    // Nothing is accepted while reset is held
    assign in_ready  = rst & g_stage[0].up_rdy;
    assign out_valid = g_stage[DEPTH-1].dn_vld;
    assign out_data  = g_stage[DEPTH-1].dn_dat;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Occupancy tracks handshakes at the chain boundary; a flush empties everything
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (in_xfer && !out_xfer) begin
            count <= count + ONE;
        end else if (!in_xfer && out_xfer) begin
            count <= count - ONE;
        end
    end

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Bench for pipe_reg_hs: queue reference model for DEPTH=2/SKID=1, directed checks for DEPTH=3/SKID=0.
// Latency: n/a.
// Backpressure: driven by directed and random out_ready patterns.
module tb_pipe_reg_hs;

    localparam int W   = 32;
    localparam int DA  = 2;
    localparam int DB  = 3;
    localparam int CWA = $clog2(2 * DA + 2);
    localparam int CWB = $clog2(2 * DB + 2);
    localparam int CAP_A = DA * 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           clr;

    logic           a_in_valid;
    logic [W-1:0]   a_in_data;
    logic           a_in_ready;
    logic           a_out_valid;
    logic [W-1:0]   a_out_data;
    logic           a_out_ready;
    logic [CWA-1:0] a_count;

    logic           b_in_valid;
    logic [W-1:0]   b_in_data;
    logic           b_in_ready;
    logic           b_out_valid;
    logic [W-1:0]   b_out_data;
    logic           b_out_ready;
    logic [CWB-1:0] b_count;

    pipe_reg_hs #(.WIDTH(W), .DEPTH(DA), .SKID(1)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_ready (a_out_ready),
        .count     (a_count)
    );

    pipe_reg_hs #(.WIDTH(W), .DEPTH(DB), .SKID(0)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_ready (b_out_ready),
        .count     (b_count)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of DUT A against the queue model; called at a negedge with inputs already driven
    task automatic step_a();
        bit           ix;
        bit           ox;
        logic [W-1:0] din;
        ix  = a_in_valid && a_in_ready;
        ox  = a_out_valid && a_out_ready;
        din = a_in_data;
        if (a_out_valid) begin
            if (q.size() == 0) chk("stale_out", {63'd0, a_out_valid}, 64'd0);
            else               chk("out_data", {32'd0, a_out_data}, {32'd0, q[0]});
        end
        @(posedge clk);
        if (!rst || clr) begin
            q.delete();
        end else begin
            if (ox) void'(q.pop_front());
            if (ix) q.push_back(din);
        end
        @(negedge clk);
        chk("count", {61'd0, a_count}, 64'(q.size()));
        if (rst && q.size() == CAP_A) chk("full_rdy", {63'd0, a_in_ready}, 64'd0);
    endtask

    task automatic drain_a();
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() != 0; k++) step_a();
        chk("drained", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int acc;
        int back;
        int pops;
        rst = 1'b0; clr = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'h5; a_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_data = 32'h5; b_out_ready = 1'b1;
        @(negedge clk);

        // 1. reset holds everything off even with in_valid high
        step_a();
        step_a();
        chk("rst_in_ready_a", {63'd0, a_in_ready}, 64'd0);
        chk("rst_out_valid_a", {63'd0, a_out_valid}, 64'd0);
        chk("rst_count_a", {61'd0, a_count}, 64'd0);
        chk("rst_out_data_a", {32'd0, a_out_data}, 64'd0);
        chk("rst_in_ready_b", {63'd0, b_in_ready}, 64'd0);
        chk("rst_out_valid_b", {63'd0, b_out_valid}, 64'd0);
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rel_in_ready_a", {63'd0, a_in_ready}, 64'd1);
        chk("rel_in_ready_b", {63'd0, b_in_ready}, 64'd1);
        @(negedge clk);

        // 2. streaming 1..8: first word visible DEPTH-1 edges after accept, then no gaps
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = W'(i);
            chk("stream_accept", {63'd0, a_in_ready}, 64'd1);
            step_a();
            if (i == 1) begin
                chk("stream_lat_early", {63'd0, a_out_valid}, 64'd0);
            end else begin
                chk("stream_valid", {63'd0, a_out_valid}, 64'd1);
                chk("stream_data", {32'd0, a_out_data}, 64'(i - 1));
                chk("stream_count", {61'd0, a_count}, 64'd2);
            end
        end
        a_in_valid = 1'b0;
        step_a();
        chk("stream_last", {32'd0, a_out_data}, 64'd8);
        step_a();
        chk("stream_empty", {63'd0, a_out_valid}, 64'd0);

        // 3. backpressure: exactly capacity words accepted, then drain in order
        a_out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'h10 + W'(i);
            if (a_in_ready) acc++;
            step_a();
        end
        chk("bp_accepted", 64'(acc), 64'd4);
        chk("bp_in_ready", {63'd0, a_in_ready}, 64'd0);
        chk("bp_count", {61'd0, a_count}, 64'd4);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        back = -1;
        for (int k = 0; k < 4; k++) begin
            step_a();
            if (back < 0 && a_in_ready) back = k;
        end
        chk("bp_ready_back", {63'd0, (back >= 0 && back <= 2)}, 64'd1);
        drain_a();

        // 4. flush with an input offered in the same cycle
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'h20 + W'(i);
            step_a();
        end
        chk("fl_count3", {61'd0, a_count}, 64'd3);
        clr = 1'b1;
        a_in_valid = 1'b1;
        a_in_data  = 32'hDEAD;
        step_a();
        clr = 1'b0;
        a_in_valid = 1'b0;
        chk("fl_out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("fl_count", {61'd0, a_count}, 64'd0);
        a_in_valid = 1'b1;
        a_in_data  = 32'h77;
        step_a();
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        step_a();
        chk("fl_first_out", {32'd0, a_out_data}, 64'h77);
        chk("fl_first_vld", {63'd0, a_out_valid}, 64'd1);
        drain_a();

        // 5. push and pop together at full capacity
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'h30 + W'(i);
            step_a();
        end
        a_out_ready = 1'b1;
        for (int i = 4; i < 12; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'h30 + W'(i);
            step_a();
            chk("full_le_cap", {63'd0, (a_count <= CWA'(CAP_A))}, 64'd1);
        end
        pops = 0;
        for (int i = 0; i < 6; i++) begin
            if (a_out_valid) pops++;
            step_a();
        end
        chk("full_sustain", {63'd0, (pops >= 5)}, 64'd1);
        drain_a();

        // random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_in_data   = $urandom;
            a_out_ready = ($urandom_range(0, 9) < 7);
            clr         = ($urandom_range(0, 49) == 0);
            step_a();
        end
        clr = 1'b0;
        drain_a();

        // 6. SKID=0, DEPTH=3: combinational ready through the whole chain
        b_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 32'hB0 + W'(i);
            #1;
            chk("b_in_ready", {63'd0, b_in_ready}, (i < 3) ? 64'd1 : 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        chk("b_count_full", {61'd0, b_count}, 64'd3);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        #1;
        chk("b_ready_comb", {63'd0, b_in_ready}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            chk("b_out_valid", {63'd0, b_out_valid}, 64'd1);
            chk("b_out_data", {32'd0, b_out_data}, 64'(32'hB0 + k));
            @(posedge clk);
            @(negedge clk);
        end
        chk("b_empty", {63'd0, b_out_valid}, 64'd0);
        chk("b_count_zero", {61'd0, b_count}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
